vga_timing_gen: RTL and testbench

Free-running raster timing generator for the 25 MHz pixel clock domain, sitting directly upstream of the pixel/sprite logic in the top level. Produces the current pixel coordinates, active-low HSYNC/VSYNC, a data-enable, and single-cycle line/frame start strobes, all mutually aligned on the same clock edge. Defaults give 640x480@60 (800x525 total). Downstream logic compares `pixelx`/`pixely` against object positions and updates positions on the VSYNC rising edge.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_timing_gen_axis_counter.sv | 40 ++++
 rtl/vga_timing_gen.sv | 96 +++++++++
 tb/tb_vga_timing_gen.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants and geometry helpers for the VGA timing generator.
// Defaults describe 640x480@60 on a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int unsigned COORD_W   = 11;
    localparam int unsigned MAX_TOTAL = 2048;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
        return active + fp;
    endfunction

    function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// Modulus counter for one raster axis; resets to the last position so the
// first enabled edge after reset lands on zero.
module axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned MODULUS = 800,
    parameter int unsigned W       = COORD_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_next_o,
    output logic         tc_o
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign tc_o         = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: pixel coordinates, active-low syncs,
// data-enable and line/frame strobes, all registered and mutually aligned.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] pixelx,
    output logic [COORD_W-1:0] pixely,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG_C = COORD_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [COORD_W-1:0] HS_END_C = COORD_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [COORD_W-1:0] VS_BEG_C = COORD_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [COORD_W-1:0] VS_END_C = COORD_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_geometry
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed %0d", MAX_TOTAL);
    end

    logic [COORD_W-1:0] hx_next, vy_next;
    logic               h_tc, v_tc;

    axis_counter #(.MODULUS(H_TOTAL), .W(COORD_W)) u_hcnt (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (1'b1),
        .count_o      (pixelx),
        .count_next_o (hx_next),
        .tc_o         (h_tc)
    );

    axis_counter #(.MODULUS(V_TOTAL), .W(COORD_W)) u_vcnt (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (h_tc),
        .count_o      (pixely),
        .count_next_o (vy_next),
        .tc_o         (v_tc)
    );

    logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic line_start_q, line_start_d, frame_start_q, frame_start_d;

    // Decode the upcoming count so the registered flags line up with the
    // registered coordinates; the strobes come from the terminal counts.
    always_comb begin
        hsync_d       = !((hx_next >= HS_BEG_C) && (hx_next < HS_END_C));
        vsync_d       = !((vy_next >= VS_BEG_C) && (vy_next < VS_END_C));
        de_d          = (hx_next < H_ACT_C) && (vy_next < V_ACT_C);
        line_start_d  = h_tc;
        frame_start_d = h_tc && v_tc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster (32x19) so
// several whole frames fit in a short run; a reference model feeds a scoreboard.
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 4, HSW = 6, HBP = 6;
    localparam int VA = 12, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
    } vis_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] pixelx, pixely;
    logic        hsync, vsync, de, line_start, frame_start;

    vis_t obs;
    vis_t rst_exp;
    vis_t exp_q[$];
    int   mx, my;
    int   checks = 0;
    int   errors = 0;

    assign obs = {pixelx, pixely, hsync, vsync, de, line_start, frame_start};

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixelx      (pixelx),
        .pixely      (pixely),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    function automatic vis_t exp_of(input int x, input int y);
        vis_t v;
        v.x  = 11'(x);
        v.y  = 11'(y);
        v.hs = !(x >= HA + HFP && x < HA + HFP + HSW);
        v.vs = !(y >= VA + VFP && y < VA + VFP + VSW);
        v.de = (x < HA) && (y < VA);
        v.ls = (x == 0);
        v.fs = (x == 0) && (y == 0);
        return v;
    endfunction

    // One clock: model follows the DUT edge, expected value queued, then sample on negedge.
    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            exp_q.push_back(exp_of(mx, my));
        end else begin
            mx = HT - 1;
            my = VT - 1;
            exp_q.push_back(rst_exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        vis_t e;
        rst_n = 1'b0;
        repeat (3) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_state got %h required %h", obs, e);
            end
        end
        rst_n = 1'b1;
        advance();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL first_edge got %h required %h", obs, e);
        end
        checks++;
        if (pixelx !== 11'd0 || pixely !== 11'd0 || de !== 1'b1 || line_start !== 1'b1 ||
            frame_start !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_fields got x=%0d y=%0d de=%b ls=%b fs=%b hs=%b vs=%b required 0 0 1 1 1 1 1",
                     pixelx, pixely, de, line_start, frame_start, hsync, vsync);
        end
    endtask

    task automatic test_frames();
        vis_t e;
        int   fs_idx[$];
        int   ls_cnt = 0;
        rst_n = 1'b0;
        advance();
        e = exp_q.pop_front();
        rst_n = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL frames_scan idx=%0d got %h required %h", i, obs, e);
            end
            if (frame_start) fs_idx.push_back(i);
            if (line_start) ls_cnt++;
        end
        checks++;
        if (fs_idx.size() != 3 || fs_idx[0] != 0 || fs_idx[1] != FRAME || fs_idx[2] != 2 * FRAME) begin
            errors++;
            $display("FAIL frame_start_positions got count=%0d required 3 at 0,%0d,%0d",
                     fs_idx.size(), FRAME, 2 * FRAME);
        end
        checks++;
        if (ls_cnt != 3 * VT) begin
            errors++;
            $display("FAIL line_start_count got %0d required %0d", ls_cnt, 3 * VT);
        end
    endtask

    task automatic test_hsync();
        vis_t e;
        int   fall_x = -1, rise_x = -1, de_fall_x = -1, low = 0;
        logic prev_hs, prev_de;
        for (int n = 0; n < FRAME + 1 && !(mx == 0 && my == 10); n++) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL hsync_seek got %h required %h", obs, e);
            end
        end
        prev_hs = hsync;
        prev_de = de;
        for (int i = 0; i < HT; i++) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL hsync_line got %h required %h", obs, e);
            end
            if (prev_hs && !hsync) fall_x = int'(pixelx);
            if (!prev_hs && hsync) rise_x = int'(pixelx);
            if (prev_de && !de) de_fall_x = int'(pixelx);
            if (!hsync) low++;
            prev_hs = hsync;
            prev_de = de;
        end
        checks++;
        if (fall_x != HA + HFP || rise_x != HA + HFP + HSW || low != HSW || de_fall_x != HA) begin
            errors++;
            $display("FAIL hsync_timing got fall=%0d rise=%0d low=%0d de_fall=%0d required %0d %0d %0d %0d",
                     fall_x, rise_x, low, de_fall_x, HA + HFP, HA + HFP + HSW, HSW, HA);
        end
    endtask

    task automatic test_vsync();
        vis_t e;
        int   fx = -1, fy = -1, rx = -1, ry = -1, low = 0, de_bad = 0;
        logic prev_vs;
        for (int n = 0; n < FRAME + 1 && !(mx == 0 && my == 0); n++) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL vsync_seek got %h required %h", obs, e);
            end
        end
        prev_vs = vsync;
        for (int i = 0; i < FRAME; i++) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL vsync_frame got %h required %h", obs, e);
            end
            if (prev_vs && !vsync) begin fx = int'(pixelx); fy = int'(pixely); end
            if (!prev_vs && vsync) begin rx = int'(pixelx); ry = int'(pixely); end
            if (!vsync) low++;
            if (int'(pixely) >= VA && de) de_bad++;
            prev_vs = vsync;
        end
        checks++;
        if (fx != 0 || fy != VA + VFP || rx != 0 || ry != VA + VFP + VSW || low != VSW * HT) begin
            errors++;
            $display("FAIL vsync_timing got fall=(%0d,%0d) rise=(%0d,%0d) low=%0d required (0,%0d) (0,%0d) %0d",
                     fx, fy, rx, ry, low, VA + VFP, VA + VFP + VSW, VSW * HT);
        end
        checks++;
        if (de_bad != 0) begin
            errors++;
            $display("FAIL de_blank_lines got %0d active cycles required 0", de_bad);
        end
    endtask

    task automatic test_wrap();
        vis_t e;
        for (int n = 0; n < FRAME + 1 && !(mx == HT - 1 && my == VA - 1); n++) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wrap_seek got %h required %h", obs, e);
            end
        end
        checks++;
        if (pixelx !== 11'(HT - 1) || pixely !== 11'(VA - 1) || de !== 1'b0) begin
            errors++;
            $display("FAIL wrap_last_active got x=%0d y=%0d de=%b required %0d %0d 0", pixelx, pixely, de, HT - 1, VA - 1);
        end
        advance();
        e = exp_q.pop_front();
        checks++;
        if (pixelx !== 11'd0 || pixely !== 11'(VA) || de !== 1'b0 || obs !== e) begin
            errors++;
            $display("FAIL wrap_first_blank got %h required %h", obs, e);
        end
        for (int n = 0; n < FRAME + 1 && !(mx == HT - 1 && my == VT - 1); n++) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wrap_seek2 got %h required %h", obs, e);
            end
        end
        checks++;
        if (pixelx !== 11'(HT - 1) || pixely !== 11'(VT - 1) || de !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL wrap_frame_end got x=%0d y=%0d de=%b fs=%b required %0d %0d 0 0",
                     pixelx, pixely, de, frame_start, HT - 1, VT - 1);
        end
        advance();
        e = exp_q.pop_front();
        checks++;
        if (pixelx !== 11'd0 || pixely !== 11'd0 || de !== 1'b1 || frame_start !== 1'b1 || obs !== e) begin
            errors++;
            $display("FAIL wrap_frame_start got %h required %h", obs, e);
        end
    endtask

    task automatic test_midreset();
        vis_t e;
        int   fs_cnt = 0, fs_at = -1;
        for (int n = 0; n < FRAME + 1 && !(mx == 10 && my == 5); n++) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL midreset_seek got %h required %h", obs, e);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== rst_exp) begin
            errors++;
            $display("FAIL midreset_immediate got %h required %h", obs, rst_exp);
        end
        repeat (5) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL midreset_hold got %h required %h", obs, e);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i <= FRAME; i++) begin
            advance();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL midreset_restart idx=%0d got %h required %h", i, obs, e);
            end
            if (frame_start && i > 0) begin fs_cnt++; fs_at = i; end
        end
        checks++;
        if (fs_cnt != 1 || fs_at != FRAME) begin
            errors++;
            $display("FAIL midreset_frame_period got count=%0d at=%0d required 1 at %0d", fs_cnt, fs_at, FRAME);
        end
    endtask

    initial begin
        rst_exp = {11'(HT - 1), 11'(VT - 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        mx = HT - 1;
        my = VT - 1;
        @(negedge clk);
        test_reset();
        test_frames();
        test_hsync();
        test_vsync();
        test_wrap();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
